// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter: CTRL/STAT/DATA/DIV register file, a small byte FIFO
// and an 8N1 serialiser whose bit time is re-sampled from DIV at every bit boundary.
module uart_tx #(
    parameter int DEPTH    = 4,
    parameter int DIV_INIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic [31:0] Din,
    input  logic        WE,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        tx
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic [15:0]   div_q, div_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [4:0]    count_q, count_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [15:0]   baud_q, baud_d;
    logic [15:0]   bitlen_q, bitlen_d;
    logic [7:0]    mem_q [DEPTH];

    logic        wr_ctrl, wr_stat, wr_data, wr_div;
    logic        full, empty, push, pop, bit_end, en;
    logic [15:0] div_eff;
    logic [7:0]  head;
    logic        unused_bits;

    assign unused_bits = ^{Addr[29:2], Din[31:16]};

    assign wr_ctrl = WE && (Addr[1:0] == 2'd0);
    assign wr_stat = WE && (Addr[1:0] == 2'd1);
    assign wr_data = WE && (Addr[1:0] == 2'd2);
    assign wr_div  = WE && (Addr[1:0] == 2'd3);

    assign en      = ctrl_q[0];
    assign full    = (count_q == 5'(DEPTH));
    assign empty   = (count_q == 5'd0);
    assign push    = wr_data && !full;
    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
    assign bit_end = (baud_q == bitlen_q - 16'd1);
    assign head    = mem_q[rptr_q];

    // FIFO storage: one write-enabled byte per entry, head read asynchronously for the pop.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (push && (wptr_q == AW'(gi))) begin
                mem_q[gi] <= Din[7:0];
            end
        end
    end

    // Serialiser next state; the bit length is captured from DIV only when a bit begins.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        baud_d   = baud_q;
        bitlen_d = bitlen_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && !empty) begin
                    pop      = 1'b1;
                    shift_d  = head;
                    bitcnt_d = 3'd0;
                    baud_d   = 16'd0;
                    bitlen_d = div_eff;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d   = 16'd0;
                    bitlen_d = div_eff;
                    state_d  = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d   = 16'd0;
                    bitlen_d = div_eff;
                    shift_d  = {1'b0, shift_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = 16'd0;
                    if (en && !empty) begin
                        pop      = 1'b1;
                        shift_d  = head;
                        bitcnt_d = 3'd0;
                        bitlen_d = div_eff;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register file and FIFO bookkeeping; "full" is the pre-edge value, so a pop on the
    // same edge does not rescue a write to a full FIFO.
    always_comb begin
        ctrl_d = wr_ctrl ? Din[1:0] : ctrl_q;
        div_d  = wr_div ? Din[15:0] : div_q;
        ovf_d  = ovf_q;
        if (wr_stat) begin
            ovf_d = 1'b0;
        end else if (wr_data && full) begin
            ovf_d = 1'b1;
        end
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ctrl_q   <= 2'd0;
            div_q    <= 16'(DIV_INIT);
            ovf_q    <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= 5'd0;
            shift_q  <= 8'd0;
            bitcnt_q <= 3'd0;
            baud_q   <= 16'd0;
            bitlen_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            div_q    <= div_d;
            ovf_q    <= ovf_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            baud_q   <= baud_d;
            bitlen_q <= bitlen_d;
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr[1:0])
            2'd0:    Dout = {30'd0, ctrl_q};
            2'd1:    Dout = {23'd0, count_q, ovf_q, empty, full, (state_q != IDLE)};
            2'd2:    Dout = 32'd0;
            default: Dout = {16'd0, div_q};
        endcase
    end

    always_comb begin
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
            default: tx = 1'b1;
        endcase
    end

    assign IRQ = ctrl_q[1] && ctrl_q[0] && empty && (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a queue-of-line-levels reference model checked every cycle,
// randomized register traffic, and directed scenarios with literal expectations.
module tb_uart_tx;

    localparam int DEPTH    = 4;
    localparam int DIV_INIT = 16;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [29:0] Addr  = 30'd1;
    logic [31:0] Din   = 32'd0;
    logic        WE    = 1'b0;
    logic [31:0] Dout;
    logic        IRQ;
    logic        tx;

    uart_tx #(.DEPTH(DEPTH), .DIV_INIT(DIV_INIT)) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .Din  (Din),
        .WE   (WE),
        .Dout (Dout),
        .IRQ  (IRQ),
        .tx   (tx)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a byte queue, the line as the current level plus a queue
    // of levels still to be sent; each level lasts the DIV in force when it begins.
    logic        m_en = 1'b0, m_im = 1'b0, m_ovf = 1'b0, m_active = 1'b0, m_cur = 1'b1;
    logic [15:0] m_div = 16'(DIV_INIT);
    logic [7:0]  m_q[$];
    logic        m_bits[$];
    int          m_rem = 0;

    function automatic int effdiv(input logic [15:0] d);
        return (d == 16'd0) ? 1 : int'(d);
    endfunction

    task automatic start_frame();
        logic [7:0] b;
        b = m_q.pop_front();
        m_bits.delete();
        for (int i = 0; i < 8; i++) m_bits.push_back(b[i]);
        m_bits.push_back(1'b1);
        m_cur    = 1'b0;
        m_rem    = effdiv(m_div);
        m_active = 1'b1;
    endtask

    function automatic logic [31:0] m_stat();
        return {23'd0, 5'(m_q.size()), m_ovf, (m_q.size() == 0), (m_q.size() == DEPTH), m_active};
    endfunction

    function automatic logic [31:0] m_dout(input logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, m_im, m_en};
            2'd1:    return m_stat();
            2'd2:    return 32'd0;
            default: return {16'd0, m_div};
        endcase
    endfunction

    initial forever begin
        logic full_pre;
        @(posedge clk or posedge reset);
        if (reset) begin
            m_en = 0; m_im = 0; m_ovf = 0; m_div = 16'(DIV_INIT);
            m_q.delete(); m_bits.delete(); m_active = 0; m_cur = 1; m_rem = 0;
        end else begin
            full_pre = (m_q.size() == DEPTH);
            if (m_active) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_bits.size() > 0) begin
                        m_cur = m_bits.pop_front();
                        m_rem = effdiv(m_div);
                    end else if (m_en && m_q.size() > 0) begin
                        start_frame();
                    end else begin
                        m_active = 0;
                    end
                end
            end else if (m_en && m_q.size() > 0) begin
                start_frame();
            end
            if (WE) begin
                case (Addr[1:0])
                    2'd0: begin m_en = Din[0]; m_im = Din[1]; end
                    2'd1: m_ovf = 1'b0;
                    2'd2: if (!full_pre) m_q.push_back(Din[7:0]); else m_ovf = 1'b1;
                    default: m_div = Din[15:0];
                endcase
            end
        end
    end

    // Per-cycle comparison of every output against the model, sampled after the edge.
    initial forever begin
        @(posedge clk);
        #2;
        check("tx", 64'(tx), 64'(m_active ? m_cur : 1'b1));
        check("irq", 64'(IRQ), 64'(m_im && m_en && m_q.size() == 0 && !m_active));
        check("dout", 64'(Dout), 64'(m_dout(Addr[1:0])));
    end

    logic        cap_tx [0:127];
    logic        cap_irq[0:127];
    logic [31:0] cap_st [0:127];

    task automatic tick(input logic we, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        WE = we; Addr = {28'd0, a}; Din = d;
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        tick(1'b1, a, d);
    endtask

    task automatic idle();
        tick(1'b0, 2'd1, 32'd0);
    endtask

    task automatic cap(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            cap_tx[i] = tx; cap_irq[i] = IRQ; cap_st[i] = Dout;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        wr(2'd0, 32'd1);
        wr(2'd3, 32'd1);
        while ((m_active || m_q.size() != 0) && g < 3000) begin
            idle();
            g++;
        end
        check("drain_bound", 64'(g < 3000), 64'd1);
        wr(2'd1, 32'd0);
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  frame;
        logic [63:0] act_v, exp_v;
        logic [7:0]  bytes[5];
        logic [7:0]  rx;
        int          n, j, first, last;

        // Reset state, visible without any clock edge.
        #1 reset = 1'b1;
        #1;
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_stat", 64'(Dout), 64'h4);
        check("rst_irq", 64'(IRQ), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Single frame 0xA5 at DIV=4.
        wr(2'd3, 32'd4); wr(2'd0, 32'd1); wr(2'd2, 32'hA5);
        cap(42);
        check("latency_tx0", 64'(cap_tx[1]), 64'd0);
        check("pre_frame_tx", 64'(cap_tx[0]), 64'd1);
        frame = 10'b1_1010_0101_0;
        act_v = '0; exp_v = '0;
        for (int i = 1; i <= 40; i++) begin
            act_v[i-1] = cap_tx[i];
            exp_v[i-1] = frame[(i-1)/4];
        end
        check("frame_a5", act_v, exp_v);
        n = 0;
        for (int i = 0; i < 42; i++) n += int'(cap_st[i][0]);
        check("busy_cycles_a5", 64'(n), 64'd40);

        // Back-to-back frames at DIV=2.
        wr(2'd0, 32'd0); wr(2'd3, 32'd2);
        wr(2'd2, 32'h01); wr(2'd2, 32'h02); wr(2'd2, 32'h03);
        idle();
        check("stat_three", 64'(Dout), 64'h30);
        wr(2'd0, 32'd1);
        cap(64);
        check("cnt_s0", 64'(cap_st[0][8:4]), 64'd3);
        check("cnt_s1", 64'(cap_st[1][8:4]), 64'd2);
        check("cnt_s21", 64'(cap_st[21][8:4]), 64'd1);
        check("cnt_s41", 64'(cap_st[41][8:4]), 64'd0);
        n = 0; first = -1; last = -1;
        for (int i = 0; i < 64; i++) if (cap_st[i][0]) begin
            n++; if (first < 0) first = i; last = i;
        end
        check("b2b_busy", 64'(n), 64'd60);
        check("b2b_first", 64'(first), 64'd1);
        check("b2b_last", 64'(last), 64'd60);
        check("b2b_stop1", 64'(cap_tx[20]), 64'd1);
        check("b2b_start2", 64'(cap_tx[21]), 64'd0);
        check("b2b_start3", 64'(cap_tx[41]), 64'd0);

        // Overflow: five writes into a four-entry FIFO with EN=0.
        wr(2'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            bytes[i] = 8'($urandom);
            wr(2'd2, {24'd0, bytes[i]});
        end
        idle();
        check("stat_ovf", 64'(Dout), 64'h4A);
        wr(2'd1, 32'hFFFF_FFFF);
        idle();
        check("stat_ovf_clr", 64'(Dout), 64'h42);
        wr(2'd0, 32'd1);
        cap(90);
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < 8; b++) rx[b] = cap_tx[20*f + 3 + 2*b];
            check($sformatf("ovf_rx%0d", f), 64'(rx), 64'(bytes[f]));
        end
        check("ovf_after", 64'(cap_st[81]), 64'h4);
        n = 0;
        for (int i = 81; i < 90; i++) n += int'(cap_tx[i]);
        check("ovf_no5th", 64'(n), 64'd9);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            int r;
            logic [31:0] d;
            r = $urandom_range(0, 99);
            d = $urandom;
            if (r < 15) begin
                wr(2'd2, d);
            end else if (r < 19) begin
                d[0] = ($urandom_range(0, 9) != 0);
                wr(2'd0, d);
            end else if (r < 23) begin
                d[15:0] = 16'($urandom_range(0, 3));
                wr(2'd3, d);
            end else if (r < 25) begin
                wr(2'd1, d);
            end else begin
                tick(1'b0, 2'($urandom_range(0, 3)), d);
            end
        end
        drain();

        // IRQ behaviour at DIV=1.
        wr(2'd3, 32'd1); wr(2'd0, 32'd3);
        idle();
        check("irq_idle", 64'(IRQ), 64'd1);
        wr(2'd2, 32'h3C);
        cap(13);
        n = 0;
        for (int i = 0; i <= 10; i++) n += int'(cap_irq[i]);
        check("irq_busy", 64'(n), 64'd0);
        check("irq_after", 64'(cap_irq[11]), 64'd1);
        wr(2'd0, 32'd1);
        idle();
        check("irq_im0", 64'(IRQ), 64'd0);

        // DIV change in the middle of START.
        wr(2'd3, 32'd8); wr(2'd2, 32'h55);
        idle(); cap_tx[0] = tx;
        idle(); cap_tx[1] = tx;
        tick(1'b0, 2'd1, 32'd0); cap_tx[2] = tx;
        wr(2'd3, 32'd2); cap_tx[3] = tx;
        for (int i = 4; i < 40; i++) begin idle(); cap_tx[i] = tx; end
        j = 1; n = 0;
        while (j < 40 && cap_tx[j] == 1'b0) begin n++; j++; end
        check("div_start_len", 64'(n), 64'd8);
        n = 0;
        while (j < 40 && cap_tx[j] == 1'b1) begin n++; j++; end
        check("div_bit0_len", 64'(n), 64'd2);
        n = 0;
        while (j < 40 && cap_tx[j] == 1'b0) begin n++; j++; end
        check("div_bit1_len", 64'(n), 64'd2);
        drain();

        // Reset during data bit 3.
        wr(2'd3, 32'd4); wr(2'd2, 32'h07);
        cap(19);
        check("pre_rst_bit2", 64'(cap_tx[16]), 64'd1);
        check("pre_rst_bit3", 64'(cap_tx[18]), 64'd0);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_tx", 64'(tx), 64'd1);
        check("rst_mid_stat", 64'(Dout), 64'h4);
        check("rst_mid_irq", 64'(IRQ), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cap(30);
        n = 0;
        for (int i = 0; i < 30; i++) n += int'(cap_tx[i]);
        check("post_rst_idle", 64'(n), 64'd30);
        check("post_rst_stat", 64'(cap_st[29]), 64'h4);
        tick(1'b0, 2'd3, 32'd0);
        check("post_rst_div", 64'(Dout), 64'(DIV_INIT));
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning transmit FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter DIV_INIT, default 16, meaning the reset value of DIV in clock cycles per bit.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Addr  input  30  word address (bus byte address [31:2]) from the bridge; only Addr[1:0] decoded.
REQ-006 SHALL have port Din  input  32  write data from the bridge.
REQ-007 SHALL have port WE  input  1  write strobe, already qualified by the bridge address decode.
REQ-008 SHALL have port Dout  output  32  read data.
REQ-009 SHALL have port IRQ  output  1  level interrupt request, wired into one HWInt bit.
REQ-010 SHALL have port tx  output  1  serial line, idle high.

Function
REQ-011 SHALL decode registers by Addr[1:0]: 0 CTRL, 1 STAT, 2 DATA, 3 DIV.
REQ-012 SHALL implement CTRL as a read/write register: bit0 EN, bit1 IM; bits[31:2] read 0.
REQ-013 SHALL make STAT read-only: bit0 busy (state!=IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[8:4] FIFO count; other bits read 0.
REQ-014 SHALL clear overflow on any write to STAT; Din is ignored.
REQ-015 SHALL push Din[7:0] into the FIFO on a DATA write when not full; DATA reads return 0.
REQ-016 SHALL drop a DATA write when full, judged by the pre-edge count even if a pop happens on the same edge, and SHALL set overflow.
REQ-017 SHALL allow a simultaneous push (not full) and pop on one edge, leaving count unchanged.
REQ-018 SHALL implement DIV as read/write bits[15:0]; a written value of 0 SHALL behave as 1.
REQ-019 SHALL drive Dout combinationally from Addr and current register state, with zero-cycle read latency.
REQ-020 SHALL implement the FSM states IDLE, START, DATA, STOP.
REQ-021 IDLE: tx=1; when EN=1 and FIFO not empty, SHALL pop the head into an 8-bit shift register, load the bit counter, and enter START on that edge.
REQ-022 START: tx=0 for DIV cycles, then SHALL enter DATA.
REQ-023 DATA: tx=shift[0], sending 8 bits LSB first, each for DIV cycles, then SHALL enter STOP.
REQ-024 STOP: tx=1 for DIV cycles; at the end, if EN=1 and not empty, SHALL pop and enter START directly (back-to-back), else enter IDLE.
REQ-025 SHALL drive tx combinationally from the state and shift register, with no extra output flop.
REQ-026 SHALL make one frame exactly 10*DIV cycles.
REQ-027 SHALL latch DIV into the baud counter only at a bit boundary; a mid-bit DIV write affects the next bit.
REQ-028 SHALL let the current frame complete when EN is cleared mid-frame, with no further pops; FIFO contents are retained.
REQ-029 SHALL drive IRQ = IM & EN & empty & (state==IDLE), combinationally.
REQ-030 SHALL make the FIFO pointers wrap modulo DEPTH, with count ranging 0..DEPTH.
REQ-031 Latency: SHALL have a DATA write at edge k into an empty FIFO while IDLE/EN cause a pop at edge k+1, with tx low from edge k+1.

Reset
REQ-032 On reset assertion, SHALL immediately, without a clock, set: CTRL=0, DIV=DIV_INIT, overflow=0, FIFO empty (pointers and count 0), state IDLE, counters 0.
REQ-033 During and after reset, SHALL give: tx=1, IRQ=0, Dout = value decoded from reset state (e.g. STAT=0x4).
REQ-034 SHALL abort any in-flight frame on reset mid-frame, with no partial bits after release.

Verification
REQ-035 Frame: DIV=4, CTRL=1, DATA=0xA5 -> tx low for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4; busy is 1 for 40 cycles.
REQ-036 Back-to-back: DEPTH=4, DIV=2; write 0x01, 0x02, 0x03 -> three contiguous 20-cycle frames, no idle gap; STAT count goes 3→2→1→0.
REQ-037 Overflow: EN=0, write 5 bytes -> count=4, full=1, overflow=1; STAT write -> overflow=0; after EN=1 only the first 4 bytes are transmitted.
REQ-038 IRQ: CTRL=3, one byte, DIV=1 -> IRQ=0 while busy, IRQ=1 the cycle after STOP ends; CTRL=1 -> IRQ=0.
REQ-039 Reset mid-frame: assert reset during DATA bit 3 -> tx=1 and STAT=0x4 without a clock edge; after release tx stays 1.
REQ-040 DIV boundary: DIV=8 mid-START, write DIV=2 -> START lasts 8 cycles, subsequent bits last 2 cycles.
